// File: rtl/clk_ratio_pkg.sv
// rtl/clk_ratio_pkg.sv - shared types and constants for the clock ratio monitor
package clk_ratio_pkg;

  // Measurement FSM: waiting for the first edge, or timing periods edge to edge
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  // Width of the consecutive-match counter; bounds LOCK_CNT to 1..15
  localparam int MATCH_W = 4;

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - two-stage sampler producing a rising-edge strobe
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_q,
  output logic rise
);

  logic sig_d;

  // Sample the input and keep the previous sample for edge comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_q <= sig_in;
      sig_d <= sig_q;
    end
  end

  assign rise = sig_q & ~sig_d;

endmodule

// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - measures period and high time of a divided clock and tracks lock
module clk_ratio_monitor
  import clk_ratio_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             ratio_err
);

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [MATCH_W-1:0] M_ONE   = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_TH = MATCH_W'(LOCK_CNT);

  logic sig_q;
  logic rise;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               same;

  edge_detect_rise u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .sig_q  (sig_q),
    .rise   (rise)
  );

  // A new measurement only extends a run if a run is already in progress;
  // after reset or overflow the held period is stale and must not count
  assign same = (cnt_q == period_q) && (hcnt_q == high_q) && (match_q != '0);

  // FSM, counters, compare and lock bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    match_d  = match_q;
    locked_d = locked_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
          if (same) begin
            match_d = (match_q >= LOCK_TH) ? match_q : match_q + M_ONE;
          end else begin
            match_d = M_ONE;
            err_d   = locked_q;
          end
          locked_d = (match_d >= LOCK_TH);
        end else if (cnt_q == CNT_MAX) begin
          // Period too long to represent: abandon it and resynchronise
          err_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + CNT_W'(sig_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign ratio_err = err_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - directed and random checks of clk_ratio_monitor against a sample-history model
module tb_clk_ratio_monitor;

  localparam int CNT_W    = 4;
  localparam int LOCK_CNT = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b1;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             ratio_err;

  clk_ratio_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .ratio_err (ratio_err)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: every registered sample since reset, and every measurement since the
  // last reset/overflow; lock is the length of the trailing identical run.
  int samp[$];
  int hp[$];
  int hh[$];
  bit m_active;
  int m_start;
  bit e_valid, e_err, e_locked;
  int e_period, e_high;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    hp.delete();
    hh.delete();
    m_active = 0;
    m_start  = 0;
    e_valid  = 0;
    e_err    = 0;
    e_locked = 0;
    e_period = 0;
    e_high   = 0;
  endtask

  task automatic model_cycle(input int c);
    bit r;
    int p, h, run;
    r = (samp[c] == 1) && (c == 0 || samp[c-1] == 0);
    e_valid = 0;
    e_err   = 0;
    if (m_active) begin
      if (r) begin
        p = c - m_start;
        h = 0;
        for (int i = m_start; i < c; i++) h += samp[i];
        e_valid  = 1;
        e_period = p;
        e_high   = h;
        if (e_locked && (hp[$] != p || hh[$] != h)) e_err = 1;
        hp.push_back(p);
        hh.push_back(h);
        run = 0;
        for (int i = hp.size() - 1; i >= 0 && hp[i] == p && hh[i] == h; i--) run++;
        e_locked = (run >= LOCK_CNT);
        m_start  = c;
      end else if (c - m_start == MAXC) begin
        e_err    = 1;
        e_locked = 0;
        m_active = 0;
        hp.delete();
        hh.delete();
      end
    end else if (r) begin
      m_active = 1;
      m_start  = c;
    end
  endtask

  task automatic check_all();
    check("valid",     valid,     e_valid);
    check("ratio_err", ratio_err, e_err);
    check("locked",    locked,    e_locked);
    check("period",    period,    e_period);
    check("high_time", high_time, e_high);
  endtask

  task automatic step(input bit b);
    if (samp.size() > 0) model_cycle(samp.size() - 1);
    sig_in = b;
    @(posedge clk);
    samp.push_back(b);
    #1;
    check_all();
  endtask

  task automatic pat(input int n, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) step(i < h);
  endtask

  initial begin
    int n, h;
    model_reset();

    // Reset state
    #45;
    check_all();
    #5 rst = 1'b0;

    // Divide-by-2, divide-by-8
    pat(2, 1, 8);
    pat(8, 4, 6);

    // Ratio switch 4 -> 8
    pat(4, 2, 5);
    pat(8, 4, 5);

    // Stuck high after lock: overflow, period holds
    repeat (20) step(1'b1);

    // Longest legal period, then one cycle too long
    pat(15, 7, 5);
    pat(16, 8, 3);

    // Duty variation 3/5 then 4/4
    pat(8, 3, 5);
    pat(8, 4, 4);
    pat(8, 3, 5);

    // Asynchronous reset between edges while locked
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pat(8, 3, 5);

    // Random ratios, duties and glitches
    repeat (40) begin
      n = int'($urandom_range(2, 17));
      h = int'($urandom_range(1, n - 1));
      pat(n, h, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 6)) step(bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Measures a divided clock generated from the system clock. The monitor samples a divide-by-N signal synchronous to `clk` and reports its period and high time in `clk` cycles. It declares lock after a run of identical measurements and flags ratio changes and lost edges. It sits beside the clock divider as its checking end: the divider produces `divideby2`/`divideby4`/`divideby8`, and this block recovers N and the duty cycle from any one of them.

## Interface
Parameters:
- `CNT_W`, 8: width of the period/high-time counters; the maximum measurable period is 2^CNT_W−1 cycles.
- `LOCK_CNT`, 3: number of consecutive identical measurements required to assert `locked`; legal range 1..15.

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `sig_in`, in, 1: divided clock under test, synchronous to `clk`.
- `period`, out, CNT_W: last measured rising-to-rising period, in `clk` cycles.
- `high_time`, out, CNT_W: number of cycles `sig_in` was sampled high within that period.
- `valid`, out, 1: one-cycle pulse; `period` and `high_time` were updated this cycle.
- `locked`, out, 1: `LOCK_CNT` consecutive measurements were identical.
- `ratio_err`, out, 1: one-cycle pulse on a mismatch while locked, or on an overflow.

## Operation
- Sampling:
  - `sig_q` registers `sig_in`; `sig_d` registers `sig_q`.
  - A rising edge is `rise = sig_q & ~sig_d`.
- States:
  - IDLE: wait for `rise`. On `rise`, load `cnt = 1` and `hcnt = 1`, then go to MEAS. No `valid` is produced.
  - MEAS: each cycle without `rise`, `cnt` increments and `hcnt` increments when `sig_q = 1`.
  - On `rise` in MEAS: `period <= cnt`, `high_time <= hcnt`, `valid <= 1`, then reload `cnt = 1`, `hcnt = 1` and stay in MEAS.
- Overflow:
  - Condition: in MEAS with `cnt` = all-ones and no `rise`.
  - Response: pulse `ratio_err`, clear `locked` and `match_cnt`, go to IDLE. `period` and `high_time` hold.
  - If `rise` arrives with `cnt` = all-ones, it is a legal measurement of 2^CNT_W−1 and is not an overflow.
- Lock tracking (`match_cnt`, 4 bits, saturating at `LOCK_CNT`):
  - On each measurement, if the new `{cnt, hcnt}` equals the held `{period, high_time}` and `match_cnt > 0`, increment `match_cnt`. Otherwise set `match_cnt = 1`.
  - `locked` is registered and equals `match_cnt >= LOCK_CNT`.
  - A mismatch while `locked = 1` pulses `ratio_err` in the same cycle as `valid` and deasserts `locked`. A mismatch while unlocked only restarts the match count.
- Reset:
  - All outputs, `sig_q`, `sig_d`, `cnt`, `hcnt` and `match_cnt` go to 0; state goes to IDLE.
  - Reset is effective immediately and at any point mid-measurement; a partial measurement is discarded.
  - If `sig_in` is high when reset releases, the first sample produces `rise`. This is legal and only starts a measurement.

## Timing
- `sig_in` sampled high at edge k (previously low) → `rise` true during cycle k → the registered update appears after edge k+1. Latency is 2 `clk` edges from the sampled transition to `valid`.
- The first `valid` comes one full period after the first `rise` following reset.
- Minimum period is 2 (divide-by-2): `period = 2`, `high_time = 1`.
- `locked` rises in the same cycle as the `LOCK_CNT`-th matching `valid`.
- `valid` and `ratio_err` are never asserted for more than one cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `clk_ratio_pkg`:
  - state enum {IDLE, MEAS};
  - `MATCH_W = 4` localparam.
- Sub-module `edge_detect_rise`: contains the `sig_q`/`sig_d` flops and produces `rise`. It is reusable by other blocks in the codebase.
- Top level contains the FSM, the counters, the compare logic and the lock logic.
- Target size is about 150 RTL lines.

## Test plan
- **Divide-by-2:** `sig_in` = divider `divideby2`, `LOCK_CNT=3`, `rst` high 50 ns then low, 10 ns half-period `clk`.
  - Every `valid`: `period = 2`, `high_time = 1`.
  - `locked = 1` at the 3rd `valid`.
  - `ratio_err` stays 0.
- **Divide-by-8:** `sig_in` = `divideby8`.
  - `period = 8`, `high_time = 4`.
  - First `valid` 2 edges after the second sampled rise.
  - `locked` at the 3rd `valid`.
- **Ratio switch:** lock on `divideby4` (4/2), then switch `sig_in` to `divideby8`.
  - The next differing `valid` carries a one-cycle `ratio_err` and `locked` drops to 0.
  - `locked` reasserts after 3 measurements of 8/4.
- **Stuck input:** hold `sig_in = 1` with `CNT_W=4` after lock.
  - `ratio_err` pulses when `cnt` hits 15 without an edge.
  - State returns to IDLE, `locked = 0`, `period` holds its previous value.
- **Reset mid-operation:** assert `rst` asynchronously between edges while locked.
  - All outputs read 0 immediately.
  - After release, no `valid` until a full period has been observed.
- **Duty variation:** 3 high / 5 low pattern.
  - `period = 8`, `high_time = 3`.
  - Changing to 4 high / 4 low while locked gives `ratio_err` and unlock.
